// File: rtl/i_fetch_queue.sv
// Instruction fetch queue: issues line fetches to the I-cache, buffers 128-bit lines and
// hands one 32-bit instruction per cycle to dispatch. Optional macro IFQ_BYPASS_EN.
module i_fetch_queue #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic         clk,
   input  logic         reset,
   output logic [31:0]  Icache_pc,
   output logic         Icache_rd_en,
   input  logic [127:0] Icache_dout,
   input  logic         Icache_dout_valid,
   input  logic         Jmp_branch_valid,
   input  logic [31:0]  Jmp_branch_address,
   input  logic         Dispatch_ren,
   output logic [31:0]  Inst,
   output logic [31:0]  Pc_out,
   output logic         Empty
);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic {S_FETCH, S_WAIT} state_t;

   state_t           r_state, w_state_nxt;
   logic [31:0]      r_fetch_pc;
   logic [CNT_W-1:0] r_count;
   logic [PTR_W-1:0] r_head, r_tail;
   logic [1:0]       r_rd_word;
   logic [127:0]     r_line [DEPTH];
   logic [31:0]      r_pc   [DEPTH];

   logic             w_capture, w_q_empty, w_pop_word, w_pop_line, w_write, w_pop_head;
   logic [31:0]      w_word_off;

   assign Icache_pc  = r_fetch_pc;
   assign w_q_empty  = (r_count == '0);
   assign w_word_off = {28'd0, r_rd_word, 2'b00};

   // A single outstanding request; a capture is only accepted in WAIT, so stale responses drop.
   always_comb begin
      w_state_nxt  = r_state;
      Icache_rd_en = 1'b0;
      w_capture    = 1'b0;
      case (r_state)
         S_FETCH: begin
            Icache_rd_en = !reset && (r_count < CNT_W'(DEPTH)) && !Jmp_branch_valid;
            if (Icache_rd_en) w_state_nxt = S_WAIT;
         end
         S_WAIT: begin
            w_capture = Icache_dout_valid && !Jmp_branch_valid;
            if (w_capture) w_state_nxt = S_FETCH;
         end
         default: w_state_nxt = S_FETCH;
      endcase
   end

`ifdef IFQ_BYPASS_EN
   logic w_bypass;
   assign w_bypass = w_q_empty && w_capture;

   always_comb begin
      Empty  = w_q_empty && !w_bypass;
      Inst   = '0;
      Pc_out = '0;
      if (w_bypass) begin
         Inst   = Icache_dout[32*r_rd_word +: 32];
         Pc_out = r_fetch_pc + w_word_off;
      end else if (!w_q_empty) begin
         Inst   = r_line[r_head][32*r_rd_word +: 32];
         Pc_out = r_pc[r_head] + w_word_off;
      end
   end

   // A bypassed line whose last word is consumed on arrival never needs a slot.
   assign w_write    = w_capture && !(w_bypass && w_pop_line);
   assign w_pop_head = w_pop_line && !w_bypass;
`else
   always_comb begin
      Empty  = w_q_empty;
      Inst   = '0;
      Pc_out = '0;
      if (!w_q_empty) begin
         Inst   = r_line[r_head][32*r_rd_word +: 32];
         Pc_out = r_pc[r_head] + w_word_off;
      end
   end

   assign w_write    = w_capture;
   assign w_pop_head = w_pop_line;
`endif

   assign w_pop_word = Dispatch_ren && !Empty && !Jmp_branch_valid;
   assign w_pop_line = w_pop_word && (r_rd_word == 2'd3);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= S_FETCH;
         r_fetch_pc <= RESET_PC & ~32'hF;
         r_count    <= '0;
         r_head     <= '0;
         r_tail     <= '0;
         r_rd_word  <= '0;
      end else if (Jmp_branch_valid) begin
         r_state    <= S_FETCH;
         r_fetch_pc <= Jmp_branch_address & ~32'hF;
         r_count    <= '0;
         r_head     <= '0;
         r_tail     <= '0;
         r_rd_word  <= Jmp_branch_address[3:2];
      end else begin
         r_state <= w_state_nxt;
         if (w_capture)  r_fetch_pc <= r_fetch_pc + 32'd16;
         if (w_write)    r_tail     <= r_tail + PTR_W'(1);
         if (w_pop_head) r_head     <= r_head + PTR_W'(1);
         if (w_pop_word) r_rd_word  <= r_rd_word + 2'd1;
         r_count <= r_count + CNT_W'(w_write) - CNT_W'(w_pop_head);
      end
   end

   // Line storage carries no reset; occupancy is tracked by the control registers alone.
   always_ff @(posedge clk) begin
      if (w_write) begin
         r_line[r_tail] <= Icache_dout;
         r_pc[r_tail]   <= r_fetch_pc;
      end
   end

endmodule

// File: tb/tb_i_fetch_queue.sv
// Bench for i_fetch_queue: table-driven fill/drain phase plus redirect, wrap and reset sequences,
// with a word-level scoreboard fed from a modelled one-cycle-latency instruction cache.
module tb_i_fetch_queue;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic         clk;
   logic         reset;
   logic [31:0]  Icache_pc;
   logic         Icache_rd_en;
   logic [127:0] Icache_dout;
   logic         Icache_dout_valid;
   logic         Jmp_branch_valid;
   logic [31:0]  Jmp_branch_address;
   logic         Dispatch_ren;
   logic [31:0]  Inst;
   logic [31:0]  Pc_out;
   logic         Empty;

   i_fetch_queue #(.DEPTH(4), .RESET_PC(RESET_PC)) dut (
      .clk                (clk),
      .reset              (reset),
      .Icache_pc          (Icache_pc),
      .Icache_rd_en       (Icache_rd_en),
      .Icache_dout        (Icache_dout),
      .Icache_dout_valid  (Icache_dout_valid),
      .Jmp_branch_valid   (Jmp_branch_valid),
      .Jmp_branch_address (Jmp_branch_address),
      .Dispatch_ren       (Dispatch_ren),
      .Inst               (Inst),
      .Pc_out             (Pc_out),
      .Empty              (Empty)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return 32'h1000_0000 + (a >> 2);
   endfunction

   assign Icache_dout = {mem_word(Icache_pc + 32'd12), mem_word(Icache_pc + 32'd8),
                         mem_word(Icache_pc + 32'd4),  mem_word(Icache_pc)};

   typedef struct {
      logic [31:0] inst;
      logic [31:0] pc;
   } exp_t;

   typedef struct {
      logic        ren;
      logic        exp_rd;
      logic [31:0] exp_icpc;
      logic        exp_empty;
   } vec_t;

   exp_t        sb[$];
   vec_t        tbl[26];
   int          n_checks;
   int          n_fail;
   int          ncap;
   logic        pend;
   logic [31:0] exp_fetch;
   logic [1:0]  skip;
   logic        s_empty, s_rd;
   logic [31:0] s_inst, s_pc, s_icpc;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic cyc(input logic rst_in, input logic jmp, input logic [31:0] addr,
                      input logic ren, input logic force_v);
      logic        acc;
      logic [31:0] a;
      exp_t        e;
      @(negedge clk);
      reset              = rst_in;
      Jmp_branch_valid   = jmp;
      Jmp_branch_address = addr;
      Dispatch_ren       = ren;
      Icache_dout_valid  = force_v | (pend & !rst_in);
      acc = pend && !jmp && !rst_in;
      if (rst_in) begin
         sb.delete();
         exp_fetch = RESET_PC & ~32'hF;
         skip      = 2'd0;
      end
      #1;
      s_empty = Empty;
      s_rd    = Icache_rd_en;
      s_inst  = Inst;
      s_pc    = Pc_out;
      s_icpc  = Icache_pc;
      check("empty", Empty, (sb.size() == 0) ? 32'd1 : 32'd0);
      check("icache_pc", Icache_pc, exp_fetch);
      if (rst_in) check("rd_en_in_reset", Icache_rd_en, 32'd0);
      if (sb.size() != 0) begin
         check("inst", Inst, sb[0].inst);
         check("pc_out", Pc_out, sb[0].pc);
      end else begin
         check("inst_empty", Inst, 32'd0);
         check("pc_out_empty", Pc_out, 32'd0);
      end
      pend = Icache_rd_en && !rst_in;
      if (!rst_in) begin
         if (jmp) begin
            sb.delete();
            exp_fetch = addr & ~32'hF;
            skip      = addr[3:2];
         end else begin
            if (ren && sb.size() != 0) void'(sb.pop_front());
            if (acc) begin
               for (int j = int'(skip); j < 4; j++) begin
                  a      = exp_fetch + 32'(4 * j);
                  e.inst = mem_word(a);
                  e.pc   = a;
                  sb.push_back(e);
               end
               skip      = 2'd0;
               exp_fetch = exp_fetch + 32'd16;
               ncap++;
            end
         end
      end
   endtask

   task automatic wait_rd(input string name);
      int k;
      k = 0;
      while (!pend && k < 20) begin
         cyc(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
         k++;
      end
      n_checks++;
      if (!pend) begin
         n_fail++;
         $display("FAIL %s: no Icache_rd_en within 20 cycles", name);
      end
   endtask

   task automatic wait_caps(input string name, input int target);
      int k;
      k = 0;
      while (ncap < target && k < 20) begin
         cyc(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
         k++;
      end
      n_checks++;
      if (ncap < target) begin
         n_fail++;
         $display("FAIL %s: captures %0d expected %0d within 20 cycles", name, ncap, target);
      end
   endtask

   task automatic wait_visible(input string name);
      int k;
      k = 0;
      cyc(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
      while (s_empty && k < 20) begin
         cyc(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
         k++;
      end
      n_checks++;
      if (s_empty) begin
         n_fail++;
         $display("FAIL %s: Empty still 1 after 20 cycles", name);
      end
   endtask

   task automatic run_ren(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      reset = 1'b1; Jmp_branch_valid = 1'b0; Jmp_branch_address = '0;
      Dispatch_ren = 1'b0; Icache_dout_valid = 1'b0;
      pend = 1'b0; exp_fetch = RESET_PC & ~32'hF; skip = 2'd0; ncap = 0;
      n_checks = 0; n_fail = 0;

      // {Dispatch_ren, Icache_rd_en, Icache_pc, Empty} per cycle after reset release
      tbl[0]  = '{1'b0, 1'b1, 32'd0,   1'b1};
      tbl[1]  = '{1'b0, 1'b0, 32'd0,   1'b1};
      tbl[2]  = '{1'b0, 1'b1, 32'd16,  1'b0};
      tbl[3]  = '{1'b0, 1'b0, 32'd16,  1'b0};
      tbl[4]  = '{1'b0, 1'b1, 32'd32,  1'b0};
      tbl[5]  = '{1'b0, 1'b0, 32'd32,  1'b0};
      tbl[6]  = '{1'b0, 1'b1, 32'd48,  1'b0};
      tbl[7]  = '{1'b0, 1'b0, 32'd48,  1'b0};
      tbl[8]  = '{1'b0, 1'b0, 32'd64,  1'b0};
      tbl[9]  = '{1'b0, 1'b0, 32'd64,  1'b0};
      tbl[10] = '{1'b1, 1'b0, 32'd64,  1'b0};
      tbl[11] = '{1'b1, 1'b0, 32'd64,  1'b0};
      tbl[12] = '{1'b1, 1'b0, 32'd64,  1'b0};
      tbl[13] = '{1'b1, 1'b0, 32'd64,  1'b0};
      tbl[14] = '{1'b1, 1'b1, 32'd64,  1'b0};
      tbl[15] = '{1'b1, 1'b0, 32'd64,  1'b0};
      tbl[16] = '{1'b1, 1'b0, 32'd80,  1'b0};
      tbl[17] = '{1'b1, 1'b0, 32'd80,  1'b0};
      tbl[18] = '{1'b1, 1'b1, 32'd80,  1'b0};
      tbl[19] = '{1'b1, 1'b0, 32'd80,  1'b0};
      tbl[20] = '{1'b1, 1'b0, 32'd96,  1'b0};
      tbl[21] = '{1'b1, 1'b0, 32'd96,  1'b0};
      tbl[22] = '{1'b1, 1'b1, 32'd96,  1'b0};
      tbl[23] = '{1'b1, 1'b0, 32'd96,  1'b0};
      tbl[24] = '{1'b1, 1'b0, 32'd112, 1'b0};
      tbl[25] = '{1'b1, 1'b0, 32'd112, 1'b0};

      for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 32'd0, 1'b0, 1'b0);

      for (int i = 0; i < 26; i++) begin
         cyc(1'b0, 1'b0, 32'd0, tbl[i].ren, 1'b0);
         check($sformatf("tbl%0d_rd_en", i), s_rd, tbl[i].exp_rd);
         check($sformatf("tbl%0d_icache_pc", i), s_icpc, tbl[i].exp_icpc);
         check($sformatf("tbl%0d_empty", i), s_empty, tbl[i].exp_empty);
      end

      // Redirect while a request is outstanding, then a spurious valid in FETCH
      wait_rd("redirect_wait");
      cyc(1'b0, 1'b1, 32'h0000_0108, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
      check("redirect_icache_pc", s_icpc, 32'h0000_0100);
      wait_visible("redirect_fill");
      check("redirect_first_pc", s_pc, 32'h0000_0108);
      check("redirect_first_inst", s_inst, 32'h1000_0042);
      run_ren(10);

      // Redirect together with Dispatch_ren while two lines are held
      cyc(1'b0, 1'b1, 32'h0000_0200, 1'b0, 1'b0);
      base = ncap;
      wait_caps("fill_two", base + 2);
      cyc(1'b0, 1'b1, 32'h0000_0300, 1'b1, 1'b0);
      cyc(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
      check("jmp_ren_empty", s_empty, 32'd1);
      wait_visible("jmp_ren_refill");
      check("jmp_ren_first_pc", s_pc, 32'h0000_0300);
      run_ren(6);

      // Fetch PC wrap at the top of the address space
      cyc(1'b0, 1'b1, 32'hFFFF_FFF0, 1'b0, 1'b0);
      base = ncap;
      wait_caps("wrap_capture", base + 1);
      cyc(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
      check("wrap_icache_pc", s_icpc, 32'h0000_0000);
      check("wrap_inst", s_inst, 32'h4FFF_FFFC);
      check("wrap_pc_out", s_pc, 32'hFFFF_FFF0);
      run_ren(8);

      // Reset while waiting on the cache, then a late valid after release
      wait_rd("reset_wait");
      cyc(1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
      check("reset_empty", s_empty, 32'd1);
      check("reset_icache_pc", s_icpc, RESET_PC);
      run_ren(12);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
